serial_mag_comparator: RTL and testbench
========================================

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be at least 2.
REQ-002 Parameter SLICE, default 1: bits compared per cycle; SHALL divide WIDTH exactly.
REQ-003 Parameter EARLY_EXIT, default 1: 1 terminates the scan at the first unequal slice; 0 always scans all slices.
REQ-004 Derived constant NSL = WIDTH/SLICE (slice count); CW = $clog2(NSL)+1.
REQ-005 One clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  operands and mode presented.
REQ-009 in_ready  output  1  block can accept operands.
REQ-010 A  input  WIDTH  first operand.
REQ-011 B  input  WIDTH  second operand.
REQ-012 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 A_greater_B, A_equal_B, A_lesser_B  output  1 each  one-hot compare result.
REQ-016 cycles  output  CW  number of slices examined for this result.

Function
REQ-017 FSM states IDLE, SCAN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: in_valid && in_ready captures A, B, signed_mode, clears slice index and slice count, moves to SCAN.
REQ-019 Signed mode: MSB of both captured operands SHALL be inverted at capture, reducing signed compare to unsigned.
REQ-020 SCAN: each cycle compares one SLICE-bit slice, MSB slice first, increments the slice count.
REQ-021 Unequal slice with EARLY_EXIT=1: latch gt/lt from that slice, go to DONE next cycle; latency = slice position + 1 cycles in SCAN.
REQ-022 EARLY_EXIT=0: first unequal slice is latched and held; later slices SHALL NOT change it; DONE after exactly NSL SCAN cycles.
REQ-023 All slices equal: A_equal_B=1 after NSL SCAN cycles.
REQ-024 DONE: out_valid=1; results and cycles SHALL stay stable until out_valid && out_ready, then go to IDLE.
REQ-025 Outside DONE the three result flags SHALL all be 0; in DONE exactly one SHALL be 1.
REQ-026 in_valid while busy SHALL be ignored; A/B changing during SCAN SHALL NOT affect the result.
REQ-027 Slice index SHALL NOT wrap: reaching the last slice always exits SCAN.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, all result flags 0, cycles=0, operand registers 0.
REQ-029 Reset asserted mid-SCAN or in DONE SHALL discard the operation; no out_valid after release until a new capture.

Structure
REQ-030 Package cmp_pkg SHALL hold the state enum (IDLE, SCAN, DONE) and the 3-bit result encoding (GT, EQ, LT).
REQ-031 Sub-module cmp_slice: combinational SLICE-bit unsigned compare giving gt/eq/lt, instantiated once.

Verification
REQ-032 WIDTH=8, SLICE=1, EARLY_EXIT=1, unsigned A=0xCA, B=0xAA -> A_greater_B=1, cycles=2.
REQ-033 Same config, A=0xF0, B=0xF0 -> A_equal_B=1, cycles=8; A=0x00, B=0x00 -> equal, cycles=8.
REQ-034 A=0x80, B=0x01: signed_mode=1 -> A_lesser_B=1, cycles=1; signed_mode=0 -> A_greater_B=1, cycles=1.
REQ-035 SLICE=4, A=0x18, B=0x30 -> A_lesser_B=1, cycles=1; EARLY_EXIT=0 same operands -> A_lesser_B=1, cycles=2.
REQ-036 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; out_ready high -> IDLE next cycle.
REQ-037 rst_n pulsed low during SCAN of A=0xFF, B=0xFE -> out_valid never asserts; next capture of A=0x01, B=0xFF gives A_lesser_B=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and
// the one-hot {greater, equal, lesser} result encoding.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit order matches the output bundle {A_greater_B, A_equal_B, A_lesser_B}.
  typedef enum logic [2:0] {
    RES_NONE = 3'b000,
    GT       = 3'b100,
    EQ       = 3'b010,
    LT       = 3'b001
  } result_t;

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one SLICE-bit chunk of the two operands.
module cmp_slice #(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_mag_comparator.sv
// Serial magnitude comparator: scans captured operands MSB slice first and
// reports a one-hot greater/equal/lesser result plus the slice count examined.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int SLICE      = 1,
  parameter  int EARLY_EXIT = 1,
  localparam int NSL        = WIDTH / SLICE,
  localparam int CW         = $clog2(NSL) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             A_greater_B,
  output logic             A_equal_B,
  output logic             A_lesser_B,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NSL > 1) ? $clog2(NSL) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  result_t          res_q, res_d;
  logic             found_q, found_d;

  logic [SLICE-1:0] a_sl, b_sl;
  logic             sl_gt, sl_eq, sl_lt;

  // Slice index 0 addresses the most significant slice.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSL; i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = a_q[WIDTH-1-i*SLICE -: SLICE];
        b_sl = b_q[WIDTH-1-i*SLICE -: SLICE];
      end
    end
  end

  cmp_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .gt (sl_gt),
    .eq (sl_eq),
    .lt (sl_lt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    found_d = found_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Flipping the sign bits maps two's-complement order onto unsigned order.
          a_d     = signed_mode ? {~A[WIDTH-1], A[WIDTH-2:0]} : A;
          b_d     = signed_mode ? {~B[WIDTH-1], B[WIDTH-2:0]} : B;
          idx_d   = '0;
          cnt_d   = '0;
          res_d   = RES_NONE;
          found_d = 1'b0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        cnt_d = cnt_q + CW'(1);
        if (!found_q && !sl_eq) begin
          found_d = 1'b1;
          if (sl_gt) begin
            res_d = GT;
          end else if (sl_lt) begin
            res_d = LT;
          end
        end
        if ((EARLY_EXIT != 0) && !sl_eq) begin
          state_d = DONE;
        end else if (idx_q == IW'(NSL - 1)) begin
          state_d = DONE;
          if (!found_q && sl_eq) begin
            res_d = EQ;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      res_q   <= RES_NONE;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      found_q <= found_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign cycles    = cnt_q;

  // Result flags are only exposed while the result is being offered.
  assign {A_greater_B, A_equal_B, A_lesser_B} = (state_q == DONE) ? res_q : RES_NONE;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator across three configurations:
// (8,1,early exit), (8,4,early exit) and (8,4,full scan).
module tb_serial_mag_comparator;

  typedef struct {
    int         cfg;
    logic       sg;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] res;
    int         cyc;
  } vec_t;

  localparam int NVEC = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] iv, ordy, sm, ir, ov, gt, eq, lt;
  logic [7:0] av [3];
  logic [7:0] bv [3];
  logic [3:0] cyc0;
  logic [1:0] cyc1, cyc2;

  int errors = 0;
  int checks = 0;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(8), .SLICE(1), .EARLY_EXIT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .A(av[0]), .B(bv[0]), .signed_mode(sm[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .A_greater_B(gt[0]), .A_equal_B(eq[0]),
    .A_lesser_B(lt[0]), .cycles(cyc0)
  );

  serial_mag_comparator #(.WIDTH(8), .SLICE(4), .EARLY_EXIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .A(av[1]), .B(bv[1]), .signed_mode(sm[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .A_greater_B(gt[1]), .A_equal_B(eq[1]),
    .A_lesser_B(lt[1]), .cycles(cyc1)
  );

  serial_mag_comparator #(.WIDTH(8), .SLICE(4), .EARLY_EXIT(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .A(av[2]), .B(bv[2]), .signed_mode(sm[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .A_greater_B(gt[2]), .A_equal_B(eq[2]),
    .A_lesser_B(lt[2]), .cycles(cyc2)
  );

  function automatic logic [3:0] get_cyc(input int k);
    case (k)
      0:       return cyc0;
      1:       return {2'b00, cyc1};
      default: return {2'b00, cyc2};
    endcase
  endfunction

  function automatic logic [2:0] get_res(input int k);
    return {gt[k], eq[k], lt[k]};
  endfunction

  task automatic check_output(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Captures one operation, then scrambles the inputs (with in_valid held
  // high) while the scan runs; returns result, cycles and observed latency.
  task automatic apply_stimulus(input int k, input logic sg, input logic [7:0] a, input logic [7:0] b,
                                output logic [2:0] res, output logic [3:0] cyc, output int lat);
    int n;
    @(negedge clk);
    iv[k] = 1'b1;
    sm[k] = sg;
    av[k] = a;
    bv[k] = b;
    @(negedge clk);
    sm[k] = ~sg;
    av[k] = ~a;
    bv[k] = 8'h5A;
    n = 0;
    while (!ov[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    iv[k] = 1'b0;
    lat = n;
    res = get_res(k);
    cyc = get_cyc(k);
  endtask

  task automatic finish_op(input int k);
    check_output("busy_in_ready", {31'd0, ir[k]}, 32'd0);
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    check_output("idle_in_ready", {31'd0, ir[k]}, 32'd1);
    check_output("idle_out_valid", {31'd0, ov[k]}, 32'd0);
    check_output("idle_flags", {29'd0, get_res(k)}, 32'd0);
  endtask

  initial begin
    logic [2:0] res;
    logic [3:0] cyc;
    int         lat;
    int         seen;

    iv   = '0;
    ordy = '0;
    sm   = '0;
    for (int k = 0; k < 3; k++) begin
      av[k] = '0;
      bv[k] = '0;
    end

    vecs[0]  = '{0, 1'b0, 8'hCA, 8'hAA, 3'b100, 2};
    vecs[1]  = '{0, 1'b0, 8'hF0, 8'hF0, 3'b010, 8};
    vecs[2]  = '{0, 1'b0, 8'h00, 8'h00, 3'b010, 8};
    vecs[3]  = '{0, 1'b1, 8'h80, 8'h01, 3'b001, 1};
    vecs[4]  = '{0, 1'b0, 8'h80, 8'h01, 3'b100, 1};
    vecs[5]  = '{0, 1'b1, 8'hFF, 8'hFE, 3'b100, 8};
    vecs[6]  = '{0, 1'b1, 8'h7F, 8'h80, 3'b100, 1};
    vecs[7]  = '{0, 1'b0, 8'h01, 8'hFF, 3'b001, 1};
    vecs[8]  = '{1, 1'b0, 8'h18, 8'h30, 3'b001, 1};
    vecs[9]  = '{1, 1'b0, 8'h35, 8'h3A, 3'b001, 2};
    vecs[10] = '{1, 1'b1, 8'h90, 8'h70, 3'b001, 1};
    vecs[11] = '{1, 1'b0, 8'hAB, 8'hAB, 3'b010, 2};
    vecs[12] = '{2, 1'b0, 8'h18, 8'h30, 3'b001, 2};
    vecs[13] = '{2, 1'b0, 8'h5A, 8'h3F, 3'b100, 2};
    vecs[14] = '{2, 1'b0, 8'h77, 8'h77, 3'b010, 2};
    vecs[15] = '{2, 1'b1, 8'h3F, 8'hC0, 3'b100, 2};

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_output("rst_in_ready", {31'd0, ir[k]}, 32'd1);
      check_output("rst_out_valid", {31'd0, ov[k]}, 32'd0);
      check_output("rst_flags", {29'd0, get_res(k)}, 32'd0);
      check_output("rst_cycles", {28'd0, get_cyc(k)}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].cfg, vecs[i].sg, vecs[i].a, vecs[i].b, res, cyc, lat);
      check_output($sformatf("vec%0d_flags", i), {29'd0, res}, {29'd0, vecs[i].res});
      check_output($sformatf("vec%0d_cycles", i), {28'd0, cyc}, vecs[i].cyc);
      check_output($sformatf("vec%0d_latency", i), lat, vecs[i].cyc);
      finish_op(vecs[i].cfg);
    end

    // Result must hold while the consumer stalls.
    apply_stimulus(0, 1'b0, 8'hCA, 8'hAA, res, cyc, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("hold_flags", {29'd0, get_res(0)}, 32'b100);
      check_output("hold_cycles", {28'd0, get_cyc(0)}, 32'd2);
      check_output("hold_out_valid", {31'd0, ov[0]}, 32'd1);
      check_output("hold_in_ready", {31'd0, ir[0]}, 32'd0);
    end
    finish_op(0);

    // Asynchronous reset in the middle of a scan discards the operation.
    @(negedge clk);
    iv[0] = 1'b1;
    sm[0] = 1'b0;
    av[0] = 8'hFF;
    bv[0] = 8'hFE;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midrst_in_ready", {31'd0, ir[0]}, 32'd1);
    check_output("midrst_out_valid", {31'd0, ov[0]}, 32'd0);
    check_output("midrst_cycles", {28'd0, get_cyc(0)}, 32'd0);
    check_output("midrst_flags", {29'd0, get_res(0)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    check_output("postrst_no_valid", seen, 32'd0);
    apply_stimulus(0, 1'b0, 8'h01, 8'hFF, res, cyc, lat);
    check_output("postrst_flags", {29'd0, res}, 32'b001);
    check_output("postrst_cycles", {28'd0, cyc}, 32'd1);
    finish_op(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
